shift_exec_stage: RTL
=====================

Name: shift_exec_stage

Overview:
- Pipelined RV32I shift execution stage with valid/ready handshakes on both sides.
- Sits between the issue/operand-read stage and writeback.
- Accepts a decoded shift op (SLL/SRL/SRA) with rs1 and shamt, registers the operands, and computes the result using the 32-bit left-shift datapath.
- Right shifts use bit-reversal around that datapath.
- Returns a registered result with its destination tag.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TAG_W, 5, width of the destination-register tag carried alongside the data.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous kill of all in-flight ops.
- in_valid  input  1  upstream offers an op.
- in_ready  output  1  stage accepts the op this cycle.
- in_op  input  2  00=SLL, 01=SRL, 11=SRA, 10=illegal.
- in_rs1  input  XLEN  operand to shift.
- in_shamt  input  5  shift amount, 0..31.
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_res  output  XLEN  shift result.
- out_tag  output  TAG_W  tag of the result.
- out_err  output  1  result came from an illegal op.

Behaviour:
- Reset: one clock, synchronous, active-low. While rst_n=0 at a rising edge:
  - s1_valid=0, out_valid=0, out_res=0, out_tag=0, out_err=0.
  - in_ready reads 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight ops. No output is produced for them.
- Two register stages:
  - S1 holds op/rs1/shamt/tag.
  - S2 is the output register.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - Producers hold data stable while valid=1 and ready=0.
  - out_* stay stable while out_valid=1 and out_ready=0.
- Control equations:
  - s2_load = s1_valid & (~out_valid | out_ready).
  - in_ready = ~s1_valid | s2_load. This is combinational from out_ready; there is no path from in_valid to in_ready.
- Latency: op accepted at edge N gives out_valid=1 after edge N+1, with no backpressure. Throughput is 1 op/cycle.
- Stall: with out_ready=0 and both stages full, in_ready=0 and all registers hold.
- Draining: out_valid drops to 0 after the accepting edge if S1 was empty.
- Arithmetic, computed in S2 from S1 contents:
  - SLL: rs1 << shamt, zero fill.
  - SRL: rs1 >> shamt, zero fill.
  - SRA: rs1 >> shamt, filled with rs1[31].
  - Right shifts: reverse rs1 bit order, left-shift, reverse the result. For SRA, OR in the mask ~(32'hFFFFFFFF >> shamt) when rs1[31]=1.
  - shamt=0 returns rs1 unchanged for all legal ops.
- Illegal op 10: out_res=0 and out_err=1. The tag is still returned and the handshake proceeds normally. out_err=0 for all legal ops.
- Flush (rst_n=1, flush=1):
  - s1_valid←0 and out_valid←0 at the edge.
  - An in_valid presented in the flush cycle is dropped, even though in_ready may read 1.
  - Data registers need not clear.
- Simultaneous events: reset dominates flush; flush dominates all transfers.

Optional Feature:
- Macro: SHIFT_EXEC_STATS_EN.
- With the macro defined, adds two outputs:
  - op_count, 32-bit: increments on each out_valid & out_ready transfer; wraps FFFFFFFF→0.
  - stall_count, 32-bit: increments each cycle out_valid & ~out_ready; wraps FFFFFFFF→0.
  - Both counters clear on reset only; flush does not clear them.
- Without the macro, neither port nor the counter logic exists, and all other behaviour is identical.

Test Plan:
- Basic: reset, then out_ready=1 and ops SLL rs1=1 shamt=8 tag=3, then SRL rs1=0x80000000 shamt=31 tag=4 on consecutive cycles.
  - Results 0x00000100/tag3 and 0x00000001/tag4 appear on consecutive cycles.
  - Each result has latency 2; out_err=0.
- SRA: rs1=0xF0000000 shamt=4 → 0xFF000000; rs1=0x70000000 shamt=4 → 0x07000000; rs1=5 shamt=0 → 5.
- Backpressure: hold out_ready=0 and offer 3 ops.
  - Exactly 2 are accepted; in_ready=0 on the third; out_res stays stable.
  - Release out_ready: all 3 results emerge in order, none lost or duplicated.
- Illegal: op=10 rs1=0xDEADBEEF tag=7 → out_res=0, out_err=1, out_tag=7. The next legal op has out_err=0.
- Flush/reset: with 2 ops in flight, assert flush for 1 cycle → out_valid=0 next cycle and no stale result appears. Repeat with rst_n=0 mid-stall → all outputs zero.
- Stats (SHIFT_EXEC_STATS_EN defined): 5 transfers with 3 stall cycles → op_count=5, stall_count=3. Preload op_count=FFFFFFFF via a long run or force, then 1 transfer → op_count=0.

Source files
------------

// File: rtl/shift_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module   : shift_exec_stage
//  Purpose  : Pipelined RV32I shift execution stage (SLL / SRL / SRA) with
//             valid/ready handshakes on the issue and writeback sides.
//             S1 registers the decoded op, S2 is the output register.
//             All three shift kinds use one left-shift datapath. Right shifts
//             bit-reverse the operand before the shift and reverse the result
//             afterwards.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    XLEN      datapath width (only 32 is supported)
//    TAG_W     destination-register tag width
//  Ports
//    clk        in   rising-edge clock
//    rst_n      in   synchronous active-low reset
//    flush      in   synchronous kill of every in-flight op
//    in_valid   in   upstream offers an op
//    in_ready   out  stage accepts the op this cycle
//    in_op      in   2'b00 SLL, 2'b01 SRL, 2'b11 SRA, 2'b10 illegal
//    in_rs1     in   operand to shift
//    in_shamt   in   shift amount 0..31
//    in_tag     in   destination tag
//    out_valid  out  result available
//    out_ready  in   downstream accepts the result
//    out_res    out  shift result
//    out_tag    out  tag of the result
//    out_err    out  result came from an illegal op
//  Optional (macro SHIFT_EXEC_STATS_EN)
//    op_count    out  count of completed output transfers (wraps)
//    stall_count out  count of cycles with out_valid & ~out_ready (wraps)
// ============================================================================
module shift_exec_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [4:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
`ifdef SHIFT_EXEC_STATS_EN
    ,
    output logic [31:0]      op_count,
    output logic [31:0]      stall_count
`endif
);

    // Op encodings. Bit 0 set means a right shift; 2'b10 is the hole in the
    // encoding and is returned as an error result.
    localparam logic [1:0] c_OP_SLL = 2'b00;
    localparam logic [1:0] c_OP_SRL = 2'b01;
    localparam logic [1:0] c_OP_ILL = 2'b10;
    localparam logic [1:0] c_OP_SRA = 2'b11;

    // ------------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------------
    logic             r_s1_valid;
    logic [1:0]       r_s1_op;
    logic [XLEN-1:0]  r_s1_rs1;
    logic [4:0]       r_s1_shamt;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_res;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_err;

    // ------------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------------
    logic w_s2_load;
    logic w_in_fire;

    // S2 takes the S1 op whenever the output register is empty or is being
    // drained this cycle. in_ready depends on out_ready only, never on
    // in_valid, so no combinational loop can form through an upstream stage.
    assign w_s2_load = r_s1_valid & (~r_out_valid | out_ready);
    assign in_ready  = ~r_s1_valid | w_s2_load;
    assign w_in_fire = in_valid & in_ready;

    // ------------------------------------------------------------------------
    // Shift datapath (operates on S1 contents, result captured into S2)
    // ------------------------------------------------------------------------
    logic            w_is_right;
    logic [XLEN-1:0] w_rs1_rev;
    logic [XLEN-1:0] w_sh_in;
    logic [XLEN-1:0] w_sh_out;
    logic [XLEN-1:0] w_sh_out_rev;
    logic [XLEN-1:0] w_unsigned_res;
    logic [XLEN-1:0] w_sra_mask;
    logic [XLEN-1:0] w_res;
    logic            w_err;

    assign w_is_right = r_s1_op[0];

    // Bit reversal of the operand and of the shifter output.
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_rev
        assign w_rs1_rev[gi]    = r_s1_rs1[XLEN-1-gi];
        assign w_sh_out_rev[gi] = w_sh_out[XLEN-1-gi];
    end

    assign w_sh_in        = w_is_right ? w_rs1_rev : r_s1_rs1;
    assign w_sh_out       = w_sh_in << r_s1_shamt;
    assign w_unsigned_res = w_is_right ? w_sh_out_rev : w_sh_out;

    // Ones in the top shamt positions; ORed in for SRA of a negative value.
    // With shamt = 0 the mask is empty, so SRA returns rs1 unchanged.
    assign w_sra_mask = ~({XLEN{1'b1}} >> r_s1_shamt);

    always_comb begin
        w_res = w_unsigned_res;
        w_err = 1'b0;
        case (r_s1_op)
            c_OP_SLL: w_res = w_unsigned_res;
            c_OP_SRL: w_res = w_unsigned_res;
            c_OP_SRA: w_res = r_s1_rs1[XLEN-1] ? (w_unsigned_res | w_sra_mask)
                                               : w_unsigned_res;
            c_OP_ILL: begin
                w_res = '0;
                w_err = 1'b1;
            end
            default: begin
                w_res = '0;
                w_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // S1: operand register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= c_OP_SLL;
            r_s1_rs1   <= '0;
            r_s1_shamt <= '0;
            r_s1_tag   <= '0;
        end else if (flush) begin
            // An op offered during flush is dropped even if in_ready is high.
            r_s1_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= in_op;
            r_s1_rs1   <= in_rs1;
            r_s1_shamt <= in_shamt;
            r_s1_tag   <= in_tag;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // S2: output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_out_tag   <= '0;
            r_out_err   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_out_res   <= w_res;
            r_out_tag   <= r_s1_tag;
            r_out_err   <= w_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign out_tag   = r_out_tag;
    assign out_err   = r_out_err;

`ifdef SHIFT_EXEC_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics counters: cleared by reset only, free-running across flush.
    // ------------------------------------------------------------------------
    logic [31:0] r_op_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if (r_out_valid & out_ready) begin
                r_op_count <= r_op_count + 32'd1;
            end
            if (r_out_valid & ~out_ready) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign op_count    = r_op_count;
    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire
